seq_divider: RTL and testbench



---
 rtl/div_pkg.sv | 25 ++
 rtl/div_step.sv | 39 +++
 rtl/seq_divider.sv | 206 ++++++++++++++++++++
 tb/tb_seq_divider.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the iterative divider (seq_divider / div_step).
//   - DEFAULT_WIDTH : default divisor/quotient/remainder width
//   - div_state_e   : controller states IDLE -> CALC -> FIX -> DONE
//   - iter_count()  : number of CALC iterations for a given width
// Optional feature macro used by the divider: DIV_SIGNED_EN.
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

    // One iteration per dividend bit.
    function automatic int iter_count(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational radix-2 restoring-division iteration on magnitudes.
// Ports:
//   rem_i  [WIDTH:0]     partial remainder in (top bit is the borrow guard)
//   quot_i [2*WIDTH-1:0] quotient accumulator in (unconsumed dividend bits
//                        sit in its upper part and shift into the remainder)
//   dv_i   [WIDTH-1:0]   divisor magnitude
//   rem_o, quot_o        state after shift / trial subtract / restore
// -----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]     rem_i,
    input  logic [2*WIDTH-1:0] quot_i,
    input  logic [WIDTH-1:0]   dv_i,
    output logic [WIDTH:0]     rem_o,
    output logic [2*WIDTH-1:0] quot_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             fits;

    always_comb begin
        shifted = {rem_i, quot_i[2*WIDTH-1]};
        diff    = shifted - {2'b00, dv_i};
        // Both operands are below 2^(WIDTH+1), so the top bit is a clean borrow.
        fits    = ~diff[WIDTH+1];
        if (fits) begin
            rem_o  = diff[WIDTH:0];
            quot_o = {quot_i[2*WIDTH-2:0], 1'b1};
        end else begin
            rem_o  = shifted[WIDTH:0];
            quot_o = {quot_i[2*WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Iterative divider: 2*WIDTH-bit dividend / WIDTH-bit divisor -> WIDTH-bit
// quotient (truncated toward zero) and remainder (sign follows dividend).
// Restoring radix-2 on magnitudes, sign fix-up in one extra cycle.
// Macro DIV_SIGNED_EN: defined -> two's-complement operands/results;
//                      undefined -> unsigned, ovf = quotient >= 2^WIDTH.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         request, accepted only when idle and not in the done cycle
//   dividend      [2*WIDTH-1:0] operand, captured on acceptance
//   divisor       [WIDTH-1:0]   operand, captured on acceptance
//   busy          high from the cycle after acceptance until done
//   done          one-cycle pulse, results valid
//   quotient, remainder, ovf, dbz   results, held until the next done
// -----------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               ovf,
    output logic               dbz
);

    localparam int ITER  = iter_count(WIDTH);
    localparam int CNT_W = $clog2(ITER + 1);

    // Control state (reset)
    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               ovf_q, ovf_d;
    logic               dbz_q, dbz_d;

    // Working datapath (no reset; always loaded before use)
    logic [WIDTH:0]     rem_q, rem_d;
    logic [2*WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0]   dv_q, dv_d;
    logic               dbz_w_q, dbz_w_d;
    logic               ovf_w_q, ovf_w_d;

    logic [WIDTH:0]     step_rem;
    logic [2*WIDTH-1:0] step_quot;

`ifdef DIV_SIGNED_EN
    localparam logic [2*WIDTH-1:0] HALF = (2*WIDTH)'(1) << (WIDTH - 1);

    logic sgn_dd_q, sgn_dd_d;
    logic sgn_dv_q, sgn_dv_d;
    logic q_neg;

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + 1'b1;
    endfunction

    assign q_neg = sgn_dd_q ^ sgn_dv_q;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .quot_i (quot_q),
        .dv_i   (dv_q),
        .rem_o  (step_rem),
        .quot_o (step_quot)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        ovf_d       = ovf_q;
        dbz_d       = dbz_q;
        rem_d       = rem_q;
        quot_d      = quot_q;
        dv_d        = dv_q;
        dbz_w_d     = dbz_w_q;
        ovf_w_d     = ovf_w_q;
`ifdef DIV_SIGNED_EN
        sgn_dd_d    = sgn_dd_q;
        sgn_dv_d    = sgn_dv_q;
`endif
        case (state_q)
            S_IDLE: begin
                // done_q marks the done cycle, where a new start is ignored.
                if (start && !done_q) begin
                    cnt_d   = '0;
                    rem_d   = '0;
                    ovf_w_d = 1'b0;
                    if (divisor == '0) begin
                        // Raw dividend kept so FIX can return its low bits.
                        dbz_w_d = 1'b1;
                        quot_d  = dividend;
                        dv_d    = divisor;
                        state_d = S_FIX;
                    end else begin
                        dbz_w_d = 1'b0;
                        state_d = S_CALC;
`ifdef DIV_SIGNED_EN
                        sgn_dd_d = dividend[2*WIDTH-1];
                        sgn_dv_d = divisor[WIDTH-1];
                        // Most-negative values map to 2^(n-1), still exact unsigned.
                        quot_d   = dividend[2*WIDTH-1] ? neg_2w(dividend) : dividend;
                        dv_d     = divisor[WIDTH-1] ? neg_w(divisor) : divisor;
`else
                        quot_d   = dividend;
                        dv_d     = divisor;
`endif
                    end
                end
            end
            S_CALC: begin
                rem_d  = step_rem;
                quot_d = step_quot;
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                if (dbz_w_q) begin
                    quot_d  = '1;
                    rem_d   = {1'b0, quot_q[WIDTH-1:0]};
                    ovf_w_d = 1'b0;
                end else begin
`ifdef DIV_SIGNED_EN
                    quot_d  = q_neg ? neg_2w(quot_q) : quot_q;
                    // Negative results may reach -2^(WIDTH-1); positive ones stop one short.
                    ovf_w_d = q_neg ? (quot_q > HALF) : (quot_q >= HALF);
                    rem_d   = {1'b0, sgn_dd_q ? neg_w(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0]};
`else
                    ovf_w_d = |quot_q[2*WIDTH-1:WIDTH];
`endif
                end
            end
            S_DONE: begin
                done_d      = 1'b1;
                quotient_d  = quot_q[WIDTH-1:0];
                remainder_d = rem_q[WIDTH-1:0];
                ovf_d       = ovf_w_q;
                dbz_d       = dbz_w_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            ovf_q       <= ovf_d;
            dbz_q       <= dbz_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q   <= rem_d;
        quot_q  <= quot_d;
        dv_q    <= dv_d;
        dbz_w_q <= dbz_w_d;
        ovf_w_q <= ovf_w_d;
`ifdef DIV_SIGNED_EN
        sgn_dd_q <= sgn_dd_d;
        sgn_dv_q <= sgn_dv_d;
`endif
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Self-checking bench for seq_divider (WIDTH=4). Expected values come from
// spec-derived constant vectors and from a plain-arithmetic reference model.
// Follows the DIV_SIGNED_EN macro of the build.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           busy, done, ovf, dbz;
    logic [W-1:0]   quotient, remainder;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] dd;
        logic [3:0] dv;
        logic [3:0] q;
        logic [3:0] r;
        logic       o;
        logic       z;
        int         lat;
    } vec_t;

    vec_t tbl[$];

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division (truncates toward zero, % follows dividend).
    function automatic void model(input logic [7:0] dd, input logic [3:0] dv,
                                  output logic [3:0] q, output logic [3:0] r,
                                  output logic o, output logic z, output int lat);
        int a, b, qt, rt;
`ifdef DIV_SIGNED_EN
        a = int'($signed(dd));
        b = int'($signed(dv));
`else
        a = int'(dd);
        b = int'(dv);
`endif
        if (b == 0) begin
            q = 4'hF; r = dd[3:0]; o = 1'b0; z = 1'b1; lat = 2;
        end else begin
            qt = a / b;
            rt = a % b;
`ifdef DIV_SIGNED_EN
            o = (qt > 7) || (qt < -8);
`else
            o = (qt > 15);
`endif
            q = qt[3:0]; r = rt[3:0]; z = 1'b0; lat = 10;
        end
    endfunction

    // Issue one operation and wait for done. inj_start >= 0 pulses start at
    // that cycle of the operation with other operands. lat = -1 on timeout.
    task automatic do_div(input logic [7:0] dd, input logic [3:0] dv, input int inj_start,
                          output logic [3:0] q, output logic [3:0] r,
                          output logic o, output logic z, output int lat,
                          output logic busy_ok);
        logic got;
        @(posedge clk); #1;
        start = 1'b1; dividend = dd; divisor = dv;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = 8'($urandom); divisor = 4'($urandom);
        lat = 0; busy_ok = 1'b1; got = 1'b0;
        q = 'x; r = 'x; o = 1'bx; z = 1'bx;
        for (int c = 0; c < 40 && !got; c++) begin
            if (done) begin
                got = 1'b1;
                if (busy) busy_ok = 1'b0;
                q = quotient; r = remainder; o = ovf; z = dbz;
            end else begin
                if (!busy) busy_ok = 1'b0;
                start = (lat == inj_start);
                @(posedge clk); #1;
                start = 1'b0;
                lat++;
            end
        end
        if (!got) lat = -1;
    endtask

    task automatic run_check(input string tag, input logic [7:0] dd, input logic [3:0] dv,
                             input logic [3:0] eq, input logic [3:0] er, input logic eo,
                             input logic ez, input int elat, input int inj_start);
        logic [3:0] q, r;
        logic o, z, bok;
        int lat;
        do_div(dd, dv, inj_start, q, r, o, z, lat, bok);
        chk({tag, " latency"}, lat, elat);
        chk({tag, " quotient"}, int'(q), int'(eq));
        chk({tag, " remainder"}, int'(r), int'(er));
        chk({tag, " ovf"}, int'(o), int'(eo));
        chk({tag, " dbz"}, int'(z), int'(ez));
        chk({tag, " busy"}, int'(bok), 1);
    endtask

    initial begin
        logic [7:0] dd;
        logic [3:0] dv, eq, er;
        logic eo, ez;
        int elat;

`ifdef DIV_SIGNED_EN
        tbl.push_back('{8'h1B, 4'h5, 4'h5, 4'h2, 1'b0, 1'b0, 10});
        tbl.push_back('{8'hE5, 4'h5, 4'hB, 4'hE, 1'b0, 1'b0, 10});
        tbl.push_back('{8'h1B, 4'hC, 4'hA, 4'h3, 1'b0, 1'b0, 10});
        tbl.push_back('{8'hC0, 4'h8, 4'h8, 4'h0, 1'b1, 1'b0, 10});
        tbl.push_back('{8'hC0, 4'h4, 4'h0, 4'h0, 1'b1, 1'b0, 10});
        tbl.push_back('{8'hE0, 4'h4, 4'h8, 4'h0, 1'b0, 1'b0, 10});
        tbl.push_back('{8'h80, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 10});
        tbl.push_back('{8'h1B, 4'h0, 4'hF, 4'hB, 1'b0, 1'b1, 2});
`else
        tbl.push_back('{8'h1B, 4'h5, 4'h5, 4'h2, 1'b0, 1'b0, 10});
        tbl.push_back('{8'hE5, 4'hF, 4'hF, 4'h4, 1'b0, 1'b0, 10});
        tbl.push_back('{8'hFF, 4'h1, 4'hF, 4'h0, 1'b1, 1'b0, 10});
        tbl.push_back('{8'h64, 4'h7, 4'hE, 4'h2, 1'b0, 1'b0, 10});
        tbl.push_back('{8'h10, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0, 10});
        tbl.push_back('{8'h1B, 4'h0, 4'hF, 4'hB, 1'b0, 1'b1, 2});
`endif

        // Reset state
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset quotient", int'(quotient), 0);
        chk("reset remainder", int'(remainder), 0);
        chk("reset ovf", int'(ovf), 0);
        chk("reset dbz", int'(dbz), 0);
        rst = 1'b0;

        // Spec vectors
        foreach (tbl[i])
            run_check($sformatf("vec%0d", i), tbl[i].dd, tbl[i].dv, tbl[i].q, tbl[i].r,
                      tbl[i].o, tbl[i].z, tbl[i].lat, -1);

        // start pulsed mid-operation is ignored
        run_check("midstart", 8'h1B, 4'h5, 4'h5, 4'h2, 1'b0, 1'b0, 10, 4);

        // start during the done cycle is ignored; results hold
        start = 1'b1; dividend = 8'h30; divisor = 4'h3;
        @(posedge clk); #1;
        start = 1'b0;
        chk("donecycle busy", int'(busy), 0);
        chk("donecycle done", int'(done), 0);
        chk("hold quotient", int'(quotient), 5);
        chk("hold remainder", int'(remainder), 2);

        // Reset in the middle of CALC discards the operation
        @(posedge clk); #1;
        start = 1'b1; dividend = 8'h64; divisor = 4'h7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst quotient", int'(quotient), 0);
        chk("midrst remainder", int'(remainder), 0);
        model(8'h64, 4'h7, eq, er, eo, ez, elat);
        run_check("afterrst", 8'h64, 4'h7, eq, er, eo, ez, elat, -1);

        // Random operations against the reference model
        for (int n = 0; n < 150; n++) begin
            dd = 8'($urandom);
            dv = (n % 10 == 0) ? 4'h0 : 4'($urandom);
            model(dd, dv, eq, er, eo, ez, elat);
            run_check($sformatf("rnd %0h/%0h", dd, dv), dd, dv, eq, er, eo, ez, elat, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
